// File: rtl/pwr_domain_seq.sv
// pwr_domain_seq -- power-domain sequencer for one switchable domain.
//
// Powers a domain down and up in a fixed order. Down: stop the clock,
// clamp the outputs, assert reset, open the power switch, then wait for
// the switch ack. Up: close the switch, wait for the ack, release reset,
// release the clamps, restart the clock. Each intermediate step is held
// for STEP_DELAY cycles. If an ack wait lasts ACK_TIMEOUT cycles, the
// sequence proceeds anyway and sets the sticky timeout flag.
//
// Ports
//   clk_i          in   single clock, all flops posedge
//   rst_i          in   asynchronous active-high reset (domain forced ON)
//   req_off_i      in   single-cycle power-down request (honoured in ON only)
//   req_on_i       in   single-cycle power-up request (honoured in OFF only)
//   switch_ack_ni  in   switch-cell ack, async to clk_i, 0 = powered
//   switch_n_o     out  switch enable, 0 = domain powered
//   iso_n_o        out  isolation, 0 = domain outputs clamped
//   rst_n_o        out  domain reset, 0 = in reset
//   clkgate_en_n_o out  clock gate, 0 = domain clock stopped
//   on_o           out  1 while in ON
//   busy_o         out  1 in any state other than ON or OFF
//   done_o         out  one-cycle pulse on entry to ON or OFF
//   timeout_o      out  sticky: an ack wait expired
//   state_dbg_o    out  current FSM state encoding, for observation
//
// Request handshake: req_off_i / req_on_i are sampled on every rising
// edge. There is no ready/back-pressure: a request that reaches the block
// while it is not in the state able to act on it is dropped, never queued.
// A request is accepted on the edge where it is high in the matching
// state, and the response is visible from the following cycle.
module pwr_domain_seq #(
  parameter int STEP_DELAY  = 2,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_off_i,
  input  logic       req_on_i,
  input  logic       switch_ack_ni,
  output logic       switch_n_o,
  output logic       iso_n_o,
  output logic       rst_n_o,
  output logic       clkgate_en_n_o,
  output logic       on_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       timeout_o,
  output logic [3:0] state_dbg_o
);

  // The step counter counts down from STEP_DELAY-1; the wait counter
  // counts up to ACK_TIMEOUT-1. Both widths hold exactly those values.
  localparam int SW = (STEP_DELAY  > 1) ? $clog2(STEP_DELAY)  : 1;
  localparam int WW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DELAY - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(ACK_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_ON          = 4'd0,
    S_CLK_OFF     = 4'd1,
    S_ISO_ON      = 4'd2,
    S_RST_ON      = 4'd3,
    S_SW_OFF_WAIT = 4'd4,
    S_OFF         = 4'd5,
    S_SW_ON_WAIT  = 4'd6,
    S_RST_OFF     = 4'd7,
    S_ISO_OFF     = 4'd8,
    S_CLK_ON      = 4'd9
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [SW-1:0]   r_step;
  logic [SW-1:0]   w_step_next;
  logic [WW-1:0]   r_wait;
  logic [WW-1:0]   w_wait_next;
  logic            r_ack_meta;
  logic            r_ack_s;
  logic            w_to_set;
  logic            w_req_acc;
  logic            w_step_done;

  logic r_switch_n, r_iso_n, r_rst_n, r_clkgate_n;
  logic r_on, r_busy, r_done, r_timeout;
  logic w_switch_n, w_iso_n, w_rst_n, w_clkgate_n;

  // Two-flop synchroniser for the asynchronous switch ack.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ack_meta <= 1'b0;
      r_ack_s    <= 1'b0;
    end else begin
      r_ack_meta <= switch_ack_ni;
      r_ack_s    <= r_ack_meta;
    end
  end

  assign w_step_done = (r_step == '0);

  always_comb begin
    w_next      = r_state;
    w_step_next = r_step;
    w_wait_next = r_wait;
    w_to_set    = 1'b0;
    w_req_acc   = 1'b0;
    case (r_state)
      S_ON: begin
        if (req_off_i) begin
          w_next      = S_CLK_OFF;
          w_step_next = STEP_LAST;
          w_req_acc   = 1'b1;
        end
      end
      S_CLK_OFF, S_ISO_ON, S_RST_OFF, S_ISO_OFF, S_CLK_ON: begin
        if (w_step_done) begin
          w_step_next = STEP_LAST;
          case (r_state)
            S_CLK_OFF: w_next = S_ISO_ON;
            S_ISO_ON:  w_next = S_RST_ON;
            S_RST_OFF: w_next = S_ISO_OFF;
            S_ISO_OFF: w_next = S_CLK_ON;
            default:   w_next = S_ON;
          endcase
        end else begin
          w_step_next = r_step - 1'b1;
        end
      end
      S_RST_ON: begin
        if (w_step_done) begin
          w_next      = S_SW_OFF_WAIT;
          w_wait_next = '0;
        end else begin
          w_step_next = r_step - 1'b1;
        end
      end
      S_SW_OFF_WAIT: begin
        // A real ack wins over an expiry landing in the same cycle.
        if (r_ack_s) begin
          w_next = S_OFF;
        end else if (r_wait == WAIT_LAST) begin
          w_next   = S_OFF;
          w_to_set = 1'b1;
        end else begin
          w_wait_next = r_wait + 1'b1;
        end
      end
      S_OFF: begin
        if (req_on_i) begin
          w_next      = S_SW_ON_WAIT;
          w_wait_next = '0;
          w_req_acc   = 1'b1;
        end
      end
      S_SW_ON_WAIT: begin
        if (!r_ack_s) begin
          w_next      = S_RST_OFF;
          w_step_next = STEP_LAST;
        end else if (r_wait == WAIT_LAST) begin
          w_next      = S_RST_OFF;
          w_step_next = STEP_LAST;
          w_to_set    = 1'b1;
        end else begin
          w_wait_next = r_wait + 1'b1;
        end
      end
      default: w_next = S_ON;
    endcase
  end

  // Control levels are a pure function of the state; they are decoded
  // from the next state and registered so they switch with the state.
  always_comb begin
    w_switch_n  = (w_next == S_SW_OFF_WAIT) || (w_next == S_OFF);
    w_rst_n     = !((w_next == S_RST_ON) || (w_next == S_SW_OFF_WAIT) ||
                    (w_next == S_OFF)    || (w_next == S_SW_ON_WAIT));
    w_iso_n     = (w_next == S_ON) || (w_next == S_CLK_OFF) ||
                  (w_next == S_ISO_OFF) || (w_next == S_CLK_ON);
    w_clkgate_n = (w_next == S_ON) || (w_next == S_CLK_ON);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_ON;
      r_step      <= '0;
      r_wait      <= '0;
      r_switch_n  <= 1'b0;
      r_iso_n     <= 1'b1;
      r_rst_n     <= 1'b1;
      r_clkgate_n <= 1'b1;
      r_on        <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_step      <= w_step_next;
      r_wait      <= w_wait_next;
      r_switch_n  <= w_switch_n;
      r_iso_n     <= w_iso_n;
      r_rst_n     <= w_rst_n;
      r_clkgate_n <= w_clkgate_n;
      r_on        <= (w_next == S_ON);
      r_busy      <= (w_next != S_ON) && (w_next != S_OFF);
      r_done      <= ((w_next == S_ON) || (w_next == S_OFF)) && (w_next != r_state);
      if (w_to_set) begin
        r_timeout <= 1'b1;
      end else if (w_req_acc) begin
        r_timeout <= 1'b0;
      end
    end
  end

  assign switch_n_o     = r_switch_n;
  assign iso_n_o        = r_iso_n;
  assign rst_n_o        = r_rst_n;
  assign clkgate_en_n_o = r_clkgate_n;
  assign on_o           = r_on;
  assign busy_o         = r_busy;
  assign done_o         = r_done;
  assign timeout_o      = r_timeout;
  assign state_dbg_o    = r_state;

endmodule

// File: tb/tb_pwr_domain_seq.sv
// tb_pwr_domain_seq -- directed bench for pwr_domain_seq with
// STEP_DELAY=2, ACK_TIMEOUT=32. Switch ack is modelled as switch_n_o
// delayed 15 cycles, with an option to hold it stuck at 0.
module tb_pwr_domain_seq;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       req_off_i = 1'b0;
  logic       req_on_i = 1'b0;
  logic       switch_ack_ni;
  logic       switch_n_o, iso_n_o, rst_n_o, clkgate_en_n_o;
  logic       on_o, busy_o, done_o, timeout_o;
  logic [3:0] state_dbg_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [22:0] exp_q[$];   // {done cycle[15:0], sw,iso,rst,cg,on,busy,to}

  logic [14:0] ack_pipe = '0;
  logic        ack_stuck0 = 1'b0;

  pwr_domain_seq #(.STEP_DELAY(2), .ACK_TIMEOUT(32)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_off_i      (req_off_i),
    .req_on_i       (req_on_i),
    .switch_ack_ni  (switch_ack_ni),
    .switch_n_o     (switch_n_o),
    .iso_n_o        (iso_n_o),
    .rst_n_o        (rst_n_o),
    .clkgate_en_n_o (clkgate_en_n_o),
    .on_o           (on_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .timeout_o      (timeout_o),
    .state_dbg_o    (state_dbg_o)
  );

  // ---------------- clock / cycle count / ack model ----------------
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    cyc      <= cyc + 1;
    ack_pipe <= {ack_pipe[13:0], switch_n_o};
  end

  assign switch_ack_ni = ack_stuck0 ? 1'b0 : ack_pipe[14];

  // ---------------- helpers ----------------
  function automatic logic [6:0] pack(input logic sw, input logic iso, input logic rst,
                                      input logic cg, input logic on, input logic busy,
                                      input logic to);
    return {sw, iso, rst, cg, on, busy, to};
  endfunction

  function automatic logic [6:0] outs();
    return {switch_n_o, iso_n_o, rst_n_o, clkgate_en_n_o, on_o, busy_o, timeout_o};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk_i) begin
    if (!rst_i && done_o) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done_o=1 expected none (cycle %0d)", cyc);
      end else begin
        chk("done_pkt", {9'd0, 16'(cyc), outs()}, {9'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Pulse one kind of request every cycle for a few cycles; nothing may move.
  task automatic idle_check(input string name, input logic on_req, input logic off_req,
                            input logic [6:0] exp_v, input logic [3:0] exp_s);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      req_on_i  = on_req;
      req_off_i = off_req;
      @(negedge clk_i);
      req_on_i  = 1'b0;
      req_off_i = 1'b0;
      chk({name, "_outs"}, 32'(outs()), 32'(exp_v));
      chk({name, "_state"}, 32'(state_dbg_o), 32'(exp_s));
    end
  endtask

  task automatic power_down(input logic stuck);
    int t;
    int last;
    last = stuck ? 39 : 25;
    @(negedge clk_i);
    t = cyc;
    req_off_i = 1'b1;
    req_on_i  = 1'b0;
    exp_q.push_back({16'(t + last), pack(1, 0, 0, 0, 0, 0, stuck)});
    for (int k = 1; k <= last; k++) begin
      @(negedge clk_i);
      req_off_i = (k == 3);   // mid-sequence: must be dropped
      req_on_i  = (k == 10);  // not in OFF: must be dropped
      if (k == 1 || k == 2) chk("dn_clk_off", 32'(outs()), 32'(pack(0, 1, 1, 0, 0, 1, 0)));
      if (k == 3 || k == 4) chk("dn_iso_on",  32'(outs()), 32'(pack(0, 0, 1, 0, 0, 1, 0)));
      if (k == 5 || k == 6) chk("dn_rst_on",  32'(outs()), 32'(pack(0, 0, 0, 0, 0, 1, 0)));
      if (k == 7 || k == last - 1) begin
        chk("dn_sw_wait", 32'(outs()), 32'(pack(1, 0, 0, 0, 0, 1, 0)));
        chk("dn_sw_wait_state", 32'(state_dbg_o), 32'd4);
      end
      if (k == last) chk("dn_off_state", 32'(state_dbg_o), 32'd5);
    end
    req_off_i = 1'b0;
    req_on_i  = 1'b0;
  endtask

  task automatic power_up(input logic both);
    int t;
    @(negedge clk_i);
    t = cyc;
    req_on_i  = 1'b1;
    req_off_i = both;
    exp_q.push_back({16'(t + 25), pack(0, 1, 1, 1, 1, 0, 0)});
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk_i);
      req_on_i  = (k == 5);   // busy: must be dropped
      req_off_i = 1'b0;
      if (k == 1 || k == 18) chk("up_sw_wait", 32'(outs()), 32'(pack(0, 0, 0, 0, 0, 1, 0)));
      if (k == 19 || k == 20) chk("up_rst_off", 32'(outs()), 32'(pack(0, 0, 1, 0, 0, 1, 0)));
      if (k == 21 || k == 22) chk("up_iso_off", 32'(outs()), 32'(pack(0, 1, 1, 0, 0, 1, 0)));
      if (k == 23 || k == 24) chk("up_clk_on",  32'(outs()), 32'(pack(0, 1, 1, 1, 0, 1, 0)));
      if (k == 25) chk("up_on_state", 32'(state_dbg_o), 32'd0);
    end
    req_on_i = 1'b0;
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    repeat (3) @(negedge clk_i);
    chk("rst_outs", 32'(outs()), 32'(pack(0, 1, 1, 1, 1, 0, 0)));
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_state", 32'(state_dbg_o), 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_outs", 32'(outs()), 32'(pack(0, 1, 1, 1, 1, 0, 0)));

    idle_check("on_ignore_req_on", 1'b1, 1'b0, pack(0, 1, 1, 1, 1, 0, 0), 4'd0);
    power_down(1'b0);
    idle_check("off_ignore_req_off", 1'b0, 1'b1, pack(1, 0, 0, 0, 0, 0, 0), 4'd5);
    power_up(1'b1);

    ack_stuck0 = 1'b1;
    power_down(1'b1);
    ack_stuck0 = 1'b0;
    idle_check("off_timeout_sticky", 1'b0, 1'b1, pack(1, 0, 0, 0, 0, 0, 1), 4'd5);
    power_up(1'b0);

    // Asynchronous reset while waiting for the switch ack.
    @(negedge clk_i);
    req_off_i = 1'b1;
    @(negedge clk_i);
    req_off_i = 1'b0;
    repeat (9) @(negedge clk_i);
    chk("ar_pre_state", 32'(state_dbg_o), 32'd4);
    @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    chk("ar_outs", 32'(outs()), 32'(pack(0, 1, 1, 1, 1, 0, 0)));
    chk("ar_done", 32'(done_o), 32'd0);
    chk("ar_state", 32'(state_dbg_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (30) @(negedge clk_i);
    chk("ar_settled_outs", 32'(outs()), 32'(pack(0, 1, 1, 1, 1, 0, 0)));

    repeat (5) @(negedge clk_i);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

endmodule

// File: doc/pwr_domain_seq.md
PWR_DOMAIN_SEQ -- requirements
Module: pwr_domain_seq

Interface
REQ-001 The block SHALL have parameter STEP_DELAY, default 2, meaning cycles held in each sequencing step (range 1..255).
REQ-002 The block SHALL have parameter ACK_TIMEOUT, default 255, meaning maximum cycles to wait for switch ack (range 1..65535).
REQ-003 The block SHALL have port clk_i  input  1  single clock; all flops posedge.
REQ-004 The block SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port req_off_i  input  1  single-cycle power-down request.
REQ-006 The block SHALL have port req_on_i  input  1  single-cycle power-up request.
REQ-007 The block SHALL have port switch_ack_ni  input  1  switch-cell ack, asynchronous to clk_i; 0 = powered.
REQ-008 The block SHALL have port switch_n_o  output  1  switch-cell enable; 0 = domain powered.
REQ-009 The block SHALL have port iso_n_o  output  1  isolation; 0 = domain outputs clamped.
REQ-010 The block SHALL have port rst_n_o  output  1  domain reset; 0 = in reset.
REQ-011 The block SHALL have port clkgate_en_n_o  output  1  clock gate; 0 = domain clock stopped.
REQ-012 The block SHALL have port on_o  output  1  1 while in state ON.
REQ-013 The block SHALL have port busy_o  output  1  1 in any state other than ON or OFF.
REQ-014 The block SHALL have port done_o  output  1  one-cycle pulse on entry to ON or OFF.
REQ-015 The block SHALL have port timeout_o  output  1  sticky flag: ack wait expired.

Function
REQ-016 The block SHALL synchronise switch_ack_ni through a 2-flop synchroniser (ack_s); sync flops reset to 0.
REQ-017 The FSM SHALL have states ON, CLK_OFF, ISO_ON, RST_ON, SW_OFF_WAIT, OFF, SW_ON_WAIT, RST_OFF, ISO_OFF, CLK_ON.
REQ-018 All outputs SHALL be registered and SHALL change in the same cycle as the state register.
REQ-019 ON: switch_n_o=0, iso_n_o=1, rst_n_o=1, clkgate_en_n_o=1.
REQ-020 Power-down: req_off_i=1 in ON -> CLK_OFF (clkgate_en_n_o=0) -> ISO_ON (iso_n_o=0) -> RST_ON (rst_n_o=0) -> SW_OFF_WAIT (switch_n_o=1); CLK_OFF, ISO_ON and RST_ON each last exactly STEP_DELAY cycles.
REQ-021 SW_OFF_WAIT SHALL exit to OFF the cycle after ack_s==1 is sampled.
REQ-022 OFF: switch_n_o=1, iso_n_o=0, rst_n_o=0, clkgate_en_n_o=0.
REQ-023 Power-up: req_on_i=1 in OFF -> SW_ON_WAIT (switch_n_o=0) -> on ack_s==0, RST_OFF (rst_n_o=1) -> ISO_OFF (iso_n_o=1) -> CLK_ON (clkgate_en_n_o=1) -> ON; RST_OFF, ISO_OFF and CLK_ON each last STEP_DELAY cycles.
REQ-024 Each asserted level SHALL persist into all following steps until that signal's own release step.
REQ-025 req_off_i SHALL be ignored outside ON; req_on_i SHALL be ignored outside OFF; requests are never queued.
REQ-026 With both requests asserted in one cycle, only the request valid for the current state SHALL take effect.
REQ-027 The wait counter SHALL clear on entry to either wait state and increment each wait cycle.
REQ-028 If ACK_TIMEOUT cycles elapse without the expected ack_s, the FSM SHALL proceed to the next state, and timeout_o SHALL be set.
REQ-029 timeout_o SHALL stay set until the next accepted request.
REQ-030 The step counter SHALL be sized for STEP_DELAY and SHALL reload on every step entry; neither counter SHALL wrap.
REQ-031 done_o SHALL pulse for 1 cycle, coincident with on_o rising or with entry to OFF.

Reset
REQ-032 rst_i=1 SHALL immediately and asynchronously force state ON, switch_n_o=0, iso_n_o=1, rst_n_o=1, clkgate_en_n_o=1, on_o=1, busy_o=0, done_o=0, timeout_o=0, counters=0, ack_s=0.
REQ-033 Reset mid-sequence SHALL abandon the sequence, with no done_o pulse.

Verification
REQ-034 Bench ack model: switch_ack_ni = switch_n_o delayed 15 cycles.
REQ-035 Power-down: STEP_DELAY=2, req_off_i at cycle t -> clkgate_en_n_o=0 @t+1, iso_n_o=0 @t+3, rst_n_o=0 @t+5, switch_n_o=1 @t+7, ack_s=1 @t+24, OFF and done_o @t+25, timeout_o=0.
REQ-036 Power-up from OFF: req_on_i at cycle t -> switch_n_o=0 @t+1, rst_n_o=1 @t+19, iso_n_o=1 @t+21, clkgate_en_n_o=1 @t+23, on_o=1 and done_o @t+25.
REQ-037 Timeout: ACK_TIMEOUT=32, switch_ack_ni stuck 0 during power-down -> OFF entered 32 cycles after SW_OFF_WAIT entry, timeout_o=1; timeout_o=0 the cycle after the next req_on_i.
REQ-038 Ignored requests: req_on_i in ON, and req_off_i during busy_o=1 -> no output or state change.
REQ-039 Async reset: rst_i asserted while in SW_OFF_WAIT, between clock edges -> all outputs reach ON values before the next edge; no done_o pulse.
